// File: rtl/cv32e40p_tb_mmio_responder.sv
// Bench-side MMIO peripheral on the core data OBI port: stdout FIFO, pass/fail/exit
// reporting and a coherent 64-bit cycle counter inside a 32-byte register window.
module cv32e40p_tb_mmio_responder #(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int unsigned STDOUT_DEPTH = 8,
  parameter logic [31:0] PASS_MAGIC   = 32'd123456789,
  parameter logic [31:0] FAIL_MAGIC   = 32'd1,
  // Counter value at reset; nonzero only to reach the 32-bit carry quickly.
  parameter logic [63:0] CYCLE_INIT   = '0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        char_valid_o,
  output logic [7:0]  char_data_o,
  input  logic        char_ready_i,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
);

  localparam int unsigned PTR_W = (STDOUT_DEPTH > 1) ? $clog2(STDOUT_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    REG_STDOUT      = 3'd0,
    REG_TEST_STATUS = 3'd1,
    REG_EXIT        = 3'd2,
    REG_CYCLE_LO    = 3'd3,
    REG_CYCLE_HI    = 3'd4,
    REG_FIFO_STAT   = 3'd5,
    REG_RSVD6       = 3'd6,
    REG_RSVD7       = 3'd7
  } reg_e;

  reg_e             reg_sel;
  logic             in_window;
  logic             stdout_wr;
  logic             full;
  logic             push;
  logic             pop;
  logic             reg_wr;
  logic             cyc_lo_rd;
  logic [31:0]      rdata_d;
  logic             err_d;

  logic [7:0]       mem [STDOUT_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [63:0]      cycle_q;
  logic [31:0]      shadow_q;
  logic             rvalid_q, err_q;
  logic [31:0]      rdata_q;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^data_addr_i[1:0];

  assign reg_sel   = reg_e'(data_addr_i[4:2]);
  assign in_window = (data_addr_i[31:5] == BASE_ADDR[31:5]);
  assign stdout_wr = data_req_i & data_we_i & in_window & (reg_sel == REG_STDOUT) & data_be_i[0];
  assign full      = (count_q == CNT_W'(STDOUT_DEPTH));
  assign pop       = char_valid_o & char_ready_i;

  // A pop in the same cycle makes room, so a full FIFO only stalls without a consumer.
  assign data_gnt_o = data_req_i & ~(stdout_wr & full & ~pop);
  assign push       = data_gnt_o & stdout_wr;
  assign reg_wr     = data_gnt_o & data_we_i & in_window & (data_be_i == 4'hF);
  assign cyc_lo_rd  = data_gnt_o & ~data_we_i & in_window & (reg_sel == REG_CYCLE_LO);

  assign char_valid_o = (count_q != '0);
  assign char_data_o  = char_valid_o ? mem[rd_ptr_q] : '0;

  always_comb begin
    rdata_d = '0;
    err_d   = ~in_window;
    case (reg_sel)
      REG_STDOUT:      rdata_d = '0;
      REG_TEST_STATUS: rdata_d = {30'b0, tests_failed_o, tests_passed_o};
      REG_EXIT:        rdata_d = exit_value_o;
      REG_CYCLE_LO:    rdata_d = cycle_q[31:0];
      REG_CYCLE_HI:    rdata_d = shadow_q;
      REG_FIFO_STAT:   rdata_d = 32'(count_q);
      REG_RSVD6,
      REG_RSVD7:       err_d   = 1'b1;
      default:         err_d   = 1'b1;
    endcase
    if (data_we_i || err_d) begin
      rdata_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q] <= data_wdata_i[7:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tests_passed_o <= 1'b0;
      tests_failed_o <= 1'b0;
      exit_valid_o   <= 1'b0;
      exit_value_o   <= '0;
    end else if (reg_wr) begin
      if (reg_sel == REG_TEST_STATUS && data_wdata_i == PASS_MAGIC) tests_passed_o <= 1'b1;
      if (reg_sel == REG_TEST_STATUS && data_wdata_i == FAIL_MAGIC) tests_failed_o <= 1'b1;
      if (reg_sel == REG_EXIT && !exit_valid_o) begin
        exit_valid_o <= 1'b1;
        exit_value_o <= data_wdata_i;
      end
    end
  end

  // The HI shadow is captured on the same edge that returns LO, so HI:LO is one sample.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_q  <= CYCLE_INIT;
      shadow_q <= '0;
    end else begin
      cycle_q <= cycle_q + 64'd1;
      if (cyc_lo_rd) shadow_q <= cycle_q[63:32];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= data_gnt_o;
      rdata_q  <= data_gnt_o ? rdata_d : '0;
      err_q    <= data_gnt_o & err_d;
    end
  end

  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;

endmodule

// File: tb/tb_cv32e40p_tb_mmio_responder.sv
// Self-checking bench: directed vector table, hand sequences for stall/carry/reset,
// and randomized traffic against a transaction-level model of the register window.
module tb_cv32e40p_tb_mmio_responder;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 8;
  localparam logic [31:0] PASS  = 32'd123456789;
  localparam logic [31:0] FAILM = 32'd1;
  localparam logic [63:0] CINIT = 64'h0000_0000_FFFF_FFF0;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        data_req_i;
  logic        data_gnt_o;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic        char_valid_o;
  logic [7:0]  char_data_o;
  logic        char_ready_i;
  logic        tests_passed_o;
  logic        tests_failed_o;
  logic        exit_valid_o;
  logic [31:0] exit_value_o;

  cv32e40p_tb_mmio_responder #(
    .BASE_ADDR   (BASE),
    .STDOUT_DEPTH(DEPTH),
    .PASS_MAGIC  (PASS),
    .FAIL_MAGIC  (FAILM),
    .CYCLE_INIT  (CINIT)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .data_req_i    (data_req_i),
    .data_gnt_o    (data_gnt_o),
    .data_addr_i   (data_addr_i),
    .data_we_i     (data_we_i),
    .data_be_i     (data_be_i),
    .data_wdata_i  (data_wdata_i),
    .data_rvalid_o (data_rvalid_o),
    .data_rdata_o  (data_rdata_o),
    .data_err_o    (data_err_o),
    .char_valid_o  (char_valid_o),
    .char_data_o   (char_data_o),
    .char_ready_i  (char_ready_i),
    .tests_passed_o(tests_passed_o),
    .tests_failed_o(tests_failed_o),
    .exit_valid_o  (exit_valid_o),
    .exit_value_o  (exit_value_o)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  logic [63:0] mcyc;
  bit          m_pass, m_fail, m_exit_v;
  logic [31:0] m_exit, m_shadow;
  logic [7:0]  exp_q[$];
  logic [7:0]  rcv_q[$];
  int          n_push;
  int          n_checked;

  // Ready is either manual or a fresh random bit each cycle
  bit   rand_ready = 1'b0;
  logic man_ready  = 1'b0;
  logic rnd_bit    = 1'b0;
  assign char_ready_i = rand_ready ? rnd_bit : man_ready;

  initial forever begin
    @(posedge clk);
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) mcyc <= CINIT;
    else         mcyc <= mcyc + 64'd1;
  end

  always @(negedge clk or negedge rst_ni) begin
    if (!rst_ni) rcv_q.delete();
    else if (char_valid_o && char_ready_i) rcv_q.push_back(char_data_o);
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  function automatic void model_reset();
    m_pass = 0; m_fail = 0; m_exit_v = 0; m_exit = '0; m_shadow = '0;
    exp_q.delete();
    n_push = 0;
    n_checked = 0;
  endfunction

  task automatic xfer(input logic [31:0] addr, input logic we, input logic [3:0] be,
                      input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
    logic        in_win;
    logic [2:0]  off;
    logic [31:0] exp_rd;
    logic        exp_err;
    bit          granted;
    bit          stall;
    in_win = (addr[31:5] == BASE[31:5]);
    off    = addr[4:2];
    data_req_i = 1'b1; data_addr_i = addr; data_we_i = we; data_be_i = be; data_wdata_i = wdata;
    granted = 0;
    exp_rd  = '0;
    exp_err = 1'b0;
    for (int c = 0; c < 200 && !granted; c++) begin
      #1;
      stall = we && in_win && off == 3'd0 && be[0] &&
              (n_push - rcv_q.size() == DEPTH) && !char_ready_i;
      chk("gnt", 64'(data_gnt_o), 64'(!stall));
      if (data_gnt_o) begin
        granted = 1;
        exp_err = !in_win || off >= 3'd6;
        if (!we && !exp_err) begin
          case (off)
            3'd1:    exp_rd = {30'b0, m_fail, m_pass};
            3'd2:    exp_rd = m_exit;
            3'd3:    exp_rd = mcyc[31:0];
            3'd4:    exp_rd = m_shadow;
            3'd5:    exp_rd = 32'(n_push - rcv_q.size());
            default: exp_rd = '0;
          endcase
        end
        if (in_win && we) begin
          if (off == 3'd0 && be[0]) begin
            exp_q.push_back(wdata[7:0]);
            n_push++;
          end
          if (off == 3'd1 && be == 4'hF && wdata == PASS)  m_pass = 1;
          if (off == 3'd1 && be == 4'hF && wdata == FAILM) m_fail = 1;
          if (off == 3'd2 && be == 4'hF && !m_exit_v) begin
            m_exit_v = 1;
            m_exit   = wdata;
          end
        end
        if (in_win && !we && off == 3'd3) m_shadow = mcyc[63:32];
      end
      @(posedge clk);
      #1;
    end
    data_req_i = 1'b0;
    rdata = data_rdata_o;
    err   = data_err_o;
    if (!granted) begin
      chk("gnt_timeout", 64'd0, 64'd1);
    end else begin
      chk("rvalid", 64'(data_rvalid_o), 64'd1);
      chk($sformatf("rdata@%0h", addr), 64'(data_rdata_o), 64'(exp_rd));
      chk($sformatf("err@%0h", addr), 64'(data_err_o), 64'(exp_err));
      chk("passed", 64'(tests_passed_o), 64'(m_pass));
      chk("failed", 64'(tests_failed_o), 64'(m_fail));
      chk("exit_valid", 64'(exit_valid_o), 64'(m_exit_v));
      chk("exit_value", 64'(exit_value_o), 64'(m_exit));
    end
  endtask

  task automatic check_stream(input string name);
    @(posedge clk);
    #1;
    for (int c = 0; c < 200 && rcv_q.size() < exp_q.size(); c++) begin
      @(posedge clk);
      #1;
    end
    chk({name, "_len"}, 64'(rcv_q.size()), 64'(exp_q.size()));
    for (int i = n_checked; i < exp_q.size() && i < rcv_q.size(); i++) begin
      chk($sformatf("%s_byte%0d", name, i), 64'(rcv_q[i]), 64'(exp_q[i]));
    end
    n_checked = exp_q.size();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t        tbl[21];
  logic [31:0] rd, lo1, hi1, lo2, hi2;
  logic        er;
  logic [31:0] a;
  logic [2:0]  off;
  logic        w;
  logic [3:0]  b;
  logic [31:0] wd;

  initial begin
    tbl[0]  = '{BASE + 32'h00, 1'b1, 4'hF, 32'h41,       32'h0, 1'b0};
    tbl[1]  = '{BASE + 32'h00, 1'b1, 4'hF, 32'h42,       32'h0, 1'b0};
    tbl[2]  = '{BASE + 32'h00, 1'b1, 4'hF, 32'h43,       32'h0, 1'b0};
    tbl[3]  = '{BASE + 32'h00, 1'b0, 4'hF, 32'h0,        32'h0, 1'b0};
    tbl[4]  = '{BASE + 32'h14, 1'b0, 4'hF, 32'h0,        32'h0, 1'b0};
    tbl[5]  = '{BASE + 32'h04, 1'b1, 4'hF, 32'd5,        32'h0, 1'b0};
    tbl[6]  = '{BASE + 32'h04, 1'b0, 4'hF, 32'h0,        32'h0, 1'b0};
    tbl[7]  = '{BASE + 32'h04, 1'b1, 4'h7, PASS,         32'h0, 1'b0};
    tbl[8]  = '{BASE + 32'h04, 1'b0, 4'hF, 32'h0,        32'h0, 1'b0};
    tbl[9]  = '{BASE + 32'h04, 1'b1, 4'hF, PASS,         32'h0, 1'b0};
    tbl[10] = '{BASE + 32'h04, 1'b0, 4'hF, 32'h0,        32'h1, 1'b0};
    tbl[11] = '{BASE + 32'h04, 1'b1, 4'hF, FAILM,        32'h0, 1'b0};
    tbl[12] = '{BASE + 32'h04, 1'b0, 4'hF, 32'h0,        32'h3, 1'b0};
    tbl[13] = '{BASE + 32'h08, 1'b1, 4'hF, 32'd0,        32'h0, 1'b0};
    tbl[14] = '{BASE + 32'h08, 1'b1, 4'hF, 32'd7,        32'h0, 1'b0};
    tbl[15] = '{BASE + 32'h08, 1'b0, 4'hF, 32'h0,        32'h0, 1'b0};
    tbl[16] = '{BASE + 32'h18, 1'b0, 4'hF, 32'h0,        32'h0, 1'b1};
    tbl[17] = '{BASE + 32'h1C, 1'b1, 4'hF, 32'h1234,     32'h0, 1'b1};
    tbl[18] = '{BASE + 32'h24, 1'b0, 4'hF, 32'h0,        32'h0, 1'b1};
    tbl[19] = '{BASE + 32'h00, 1'b1, 4'hE, 32'h55,       32'h0, 1'b0};
    tbl[20] = '{BASE + 32'h07, 1'b0, 4'hF, 32'h0,        32'h3, 1'b0};

    rst_ni = 1'b0;
    data_req_i = 1'b0; data_addr_i = '0; data_we_i = 1'b0; data_be_i = '0; data_wdata_i = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rvalid", 64'(data_rvalid_o), 64'd0);
    chk("rst_rdata", 64'(data_rdata_o), 64'd0);
    chk("rst_err", 64'(data_err_o), 64'd0);
    chk("rst_char_valid", 64'(char_valid_o), 64'd0);
    chk("rst_char_data", 64'(char_data_o), 64'd0);
    chk("rst_flags", 64'({tests_passed_o, tests_failed_o, exit_valid_o}), 64'd0);
    chk("rst_exit_value", 64'(exit_value_o), 64'd0);
    chk("rst_gnt_idle", 64'(data_gnt_o), 64'd0);
    data_req_i = 1'b1;
    #1;
    chk("rst_gnt_follows_req", 64'(data_gnt_o), 64'd1);
    data_req_i = 1'b0;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;

    // Directed table with a free-running consumer
    man_ready = 1'b1;
    foreach (tbl[i]) begin
      xfer(tbl[i].addr, tbl[i].we, tbl[i].be, tbl[i].wdata, rd, er);
      chk($sformatf("tbl%0d_rdata", i), 64'(rd), 64'(tbl[i].exp_rdata));
      chk($sformatf("tbl%0d_err", i), 64'(er), 64'(tbl[i].exp_err));
    end
    check_stream("abc");
    chk("abc_order", 64'({rcv_q[0], rcv_q[1], rcv_q[2]}), 64'(24'h414243));

    // Fill to depth with no consumer; the ninth write waits for a pop
    man_ready = 1'b0;
    for (int i = 0; i < 8; i++) xfer(BASE, 1'b1, 4'hF, 32'h60 + 32'(i), rd, er);
    xfer(BASE + 32'h14, 1'b0, 4'hF, 32'h0, rd, er);
    chk("fifo_stat_full", 64'(rd), 64'd8);
    fork
      xfer(BASE, 1'b1, 4'hF, 32'h68, rd, er);
      begin
        repeat (3) @(posedge clk);
        #1;
        man_ready = 1'b1;
      end
    join
    check_stream("stall");

    // Coherent HI:LO across the 32-bit carry
    do_reset();
    for (int c = 0; c < 64 && mcyc[31:0] != 32'hFFFF_FFFF; c++) begin
      @(posedge clk);
      #1;
    end
    xfer(BASE + 32'h0C, 1'b0, 4'hF, 32'h0, lo1, er);
    xfer(BASE + 32'h10, 1'b0, 4'hF, 32'h0, hi1, er);
    chk("carry_lo1", 64'(lo1), 64'hFFFF_FFFF);
    chk("carry_hi1_snapshot", 64'(hi1), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    xfer(BASE + 32'h0C, 1'b0, 4'hF, 32'h0, lo2, er);
    xfer(BASE + 32'h10, 1'b0, 4'hF, 32'h0, hi2, er);
    chk("carry_hi2", 64'(hi2), 64'd1);
    chk("carry_monotonic", 64'({hi2, lo2} > {hi1, lo1}), 64'd1);

    // Randomized traffic with a random consumer
    do_reset();
    rand_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      off = 3'($urandom_range(0, 7));
      w   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        off = 3'd0;
        w   = 1'b1;
      end
      if ($urandom_range(0, 9) == 0)
        a = {BASE[31:5] ^ 27'($urandom_range(1, 1000)), off, 2'($urandom)};
      else
        a = {BASE[31:5], off, 2'($urandom)};
      b = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      case ($urandom_range(0, 3))
        0:       wd = PASS;
        1:       wd = FAILM;
        default: wd = $urandom;
      endcase
      xfer(a, w, b, wd, rd, er);
    end
    rand_ready = 1'b0;
    man_ready  = 1'b1;
    check_stream("rand");

    // Asynchronous reset with bytes queued, pass set and a request in flight
    do_reset();
    man_ready = 1'b0;
    for (int i = 0; i < 3; i++) xfer(BASE, 1'b1, 4'hF, 32'h70 + 32'(i), rd, er);
    xfer(BASE + 32'h04, 1'b1, 4'hF, PASS, rd, er);
    data_req_i = 1'b1; data_addr_i = BASE + 32'h0C; data_we_i = 1'b0; data_be_i = 4'hF;
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_passed", 64'(tests_passed_o), 64'd0);
    chk("mid_rst_char_valid", 64'(char_valid_o), 64'd0);
    chk("mid_rst_char_data", 64'(char_data_o), 64'd0);
    chk("mid_rst_rvalid", 64'(data_rvalid_o), 64'd0);
    chk("mid_rst_gnt", 64'(data_gnt_o), 64'd1);
    data_req_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("post_rst_no_rvalid", 64'(data_rvalid_o), 64'd0);
      chk("post_rst_empty", 64'(char_valid_o), 64'd0);
    end
    xfer(BASE + 32'h14, 1'b0, 4'hF, 32'h0, rd, er);
    chk("post_rst_fifo_stat", 64'(rd), 64'd0);
    xfer(BASE + 32'h04, 1'b0, 4'hF, 32'h0, rd, er);
    chk("post_rst_status", 64'(rd), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
